// File: rtl/implication_monitor_if.sv
// rtl/implication_monitor_if.sv - stimulus and result bundle for the x-implies-y monitor
interface implication_monitor_if #(
  parameter int COUNT_WIDTH = 16,
  parameter int TS_WIDTH    = 32
);
  logic                   x;
  logic                   y;
  logic                   en;
  logic                   clr;
  logic                   pass_pulse;
  logic                   fail_pulse;
  logic                   fail_sticky;
  logic [COUNT_WIDTH-1:0] pass_count;
  logic [COUNT_WIDTH-1:0] fail_count;
  logic                   pending;
  logic [TS_WIDTH-1:0]    first_fail_ts;

  modport master (
    output x, y, en, clr,
    input  pass_pulse, fail_pulse, fail_sticky, pass_count, fail_count, pending, first_fail_ts
  );

  modport slave (
    input  x, y, en, clr,
    output pass_pulse, fail_pulse, fail_sticky, pass_count, fail_count, pending, first_fail_ts
  );
endinterface

// File: rtl/implication_monitor.sv
// rtl/implication_monitor.sv - checks "x implies y exactly DELAY cycles later" in hardware
module implication_monitor #(
  parameter int DELAY       = 1,
  parameter int COUNT_WIDTH = 16,
  parameter int TS_WIDTH    = 32
) (
  input logic                 CLK,
  input logic                 RESET,
  implication_monitor_if.slave mon
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [DELAY-1:0]       ob;
  logic [DELAY-1:0]       ob_shift;
  logic [TS_WIDTH-1:0]    ts;
  logic                   pass_pulse_q;
  logic                   fail_pulse_q;
  logic                   fail_sticky_q;
  logic [COUNT_WIDTH-1:0] pass_count_q;
  logic [COUNT_WIDTH-1:0] fail_count_q;
  logic [TS_WIDTH-1:0]    first_fail_ts_q;
  logic                   new_ob;
  logic                   due;

  assign new_ob = mon.x & mon.en;
  assign due    = ob[DELAY-1];

  // A one-deep pipeline has nothing to shift, so it is built separately.
  generate
    if (DELAY == 1) begin : g_single
      assign ob_shift = new_ob;
    end else begin : g_multi
      assign ob_shift = {ob[DELAY-2:0], new_ob};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ob              <= '0;
      ts              <= '0;
      pass_pulse_q    <= 1'b0;
      fail_pulse_q    <= 1'b0;
      fail_sticky_q   <= 1'b0;
      pass_count_q    <= '0;
      fail_count_q    <= '0;
      first_fail_ts_q <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      if (mon.clr) begin
        // Soft clear drops everything in flight, including the obligation due now.
        ob              <= '0;
        pass_pulse_q    <= 1'b0;
        fail_pulse_q    <= 1'b0;
        fail_sticky_q   <= 1'b0;
        pass_count_q    <= '0;
        fail_count_q    <= '0;
        first_fail_ts_q <= '0;
      end else begin
        ob           <= ob_shift;
        pass_pulse_q <= due & mon.y;
        fail_pulse_q <= due & ~mon.y;
        if (due && mon.y && pass_count_q != CNT_MAX) begin
          pass_count_q <= pass_count_q + COUNT_WIDTH'(1);
        end
        if (due && !mon.y) begin
          if (fail_count_q != CNT_MAX) begin
            fail_count_q <= fail_count_q + COUNT_WIDTH'(1);
          end
          if (!fail_sticky_q) begin
            fail_sticky_q   <= 1'b1;
            first_fail_ts_q <= ts;
          end
        end
      end
    end
  end

  assign mon.pass_pulse    = pass_pulse_q;
  assign mon.fail_pulse    = fail_pulse_q;
  assign mon.fail_sticky   = fail_sticky_q;
  assign mon.pass_count    = pass_count_q;
  assign mon.fail_count    = fail_count_q;
  assign mon.pending       = |ob;
  assign mon.first_fail_ts = first_fail_ts_q;

endmodule

// File: tb/tb_implication_monitor.sv
// tb/tb_implication_monitor.sv - directed self-checking bench for implication_monitor
module tb_implication_monitor;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic x = 1'b0;
  logic y = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  // m1: DELAY=1, m2: DELAY=2, m3: DELAY=3, m4: DELAY=1 with 4-bit counters
  implication_monitor_if #(.COUNT_WIDTH(16), .TS_WIDTH(32)) m1 ();
  implication_monitor_if #(.COUNT_WIDTH(16), .TS_WIDTH(32)) m2 ();
  implication_monitor_if #(.COUNT_WIDTH(16), .TS_WIDTH(32)) m3 ();
  implication_monitor_if #(.COUNT_WIDTH(4),  .TS_WIDTH(32)) m4 ();

  assign m1.x = x;  assign m1.y = y;  assign m1.en = en;  assign m1.clr = clr;
  assign m2.x = x;  assign m2.y = y;  assign m2.en = en;  assign m2.clr = clr;
  assign m3.x = x;  assign m3.y = y;  assign m3.en = en;  assign m3.clr = clr;
  assign m4.x = x;  assign m4.y = y;  assign m4.en = en;  assign m4.clr = clr;

  implication_monitor #(.DELAY(1), .COUNT_WIDTH(16), .TS_WIDTH(32)) u1 (.CLK(CLK), .RESET(RESET), .mon(m1));
  implication_monitor #(.DELAY(2), .COUNT_WIDTH(16), .TS_WIDTH(32)) u2 (.CLK(CLK), .RESET(RESET), .mon(m2));
  implication_monitor #(.DELAY(3), .COUNT_WIDTH(16), .TS_WIDTH(32)) u3 (.CLK(CLK), .RESET(RESET), .mon(m3));
  implication_monitor #(.DELAY(1), .COUNT_WIDTH(4),  .TS_WIDTH(32)) u4 (.CLK(CLK), .RESET(RESET), .mon(m4));

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  // Leaves the bench in the first cycle after reset, which is ts=0.
  task automatic do_reset();
    RESET = 1'b1; x = 1'b0; y = 1'b0; en = 1'b0; clr = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m1.pass_pulse !== 1'b0) begin failures++; $display("FAIL reset_pass_pulse got=%b exp=0", m1.pass_pulse); end
    checks++; if (m1.fail_pulse !== 1'b0) begin failures++; $display("FAIL reset_fail_pulse got=%b exp=0", m1.fail_pulse); end
    checks++; if (m1.fail_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0", m1.fail_sticky); end
    checks++; if (m1.pass_count !== 16'd0) begin failures++; $display("FAIL reset_pass_count got=%0d exp=0", m1.pass_count); end
    checks++; if (m1.fail_count !== 16'd0) begin failures++; $display("FAIL reset_fail_count got=%0d exp=0", m1.fail_count); end
    checks++; if (m1.pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", m1.pending); end
    checks++; if (m1.first_fail_ts !== 32'd0) begin failures++; $display("FAIL reset_first_fail_ts got=%0d exp=0", m1.first_fail_ts); end
  endtask

  task automatic test_pass();
    do_reset();
    en = 1'b1;
    go_to(5);
    x = 1'b1;
    checks++; if (m1.pending !== 1'b0) begin failures++; $display("FAIL pass_pending_ts5 got=%b exp=0", m1.pending); end
    tick();
    x = 1'b0; y = 1'b1;
    checks++; if (m1.pending !== 1'b1) begin failures++; $display("FAIL pass_pending_ts6 got=%b exp=1", m1.pending); end
    checks++; if (m1.pass_pulse !== 1'b0) begin failures++; $display("FAIL pass_pulse_ts6 got=%b exp=0", m1.pass_pulse); end
    tick();
    y = 1'b0;
    checks++; if (m1.pass_pulse !== 1'b1) begin failures++; $display("FAIL pass_pulse_ts7 got=%b exp=1", m1.pass_pulse); end
    checks++; if (m1.pending !== 1'b0) begin failures++; $display("FAIL pass_pending_ts7 got=%b exp=0", m1.pending); end
    checks++; if (m1.pass_count !== 16'd1) begin failures++; $display("FAIL pass_count got=%0d exp=1", m1.pass_count); end
    checks++; if (m1.fail_count !== 16'd0) begin failures++; $display("FAIL pass_fail_count got=%0d exp=0", m1.fail_count); end
    checks++; if (m1.fail_sticky !== 1'b0) begin failures++; $display("FAIL pass_sticky got=%b exp=0", m1.fail_sticky); end
    tick();
    checks++; if (m1.pass_pulse !== 1'b0) begin failures++; $display("FAIL pass_pulse_ts8 got=%b exp=0", m1.pass_pulse); end
  endtask

  task automatic test_fail_first_ts();
    do_reset();
    en = 1'b1;
    go_to(10);
    x = 1'b1;
    tick();
    x = 1'b0; y = 1'b0;
    tick();
    checks++; if (m1.fail_pulse !== 1'b1) begin failures++; $display("FAIL fail_pulse_ts12 got=%b exp=1", m1.fail_pulse); end
    checks++; if (m1.fail_sticky !== 1'b1) begin failures++; $display("FAIL fail_sticky got=%b exp=1", m1.fail_sticky); end
    checks++; if (m1.first_fail_ts !== 32'd11) begin failures++; $display("FAIL first_fail_ts got=%0d exp=11", m1.first_fail_ts); end
    checks++; if (m1.fail_count !== 16'd1) begin failures++; $display("FAIL fail_count_1 got=%0d exp=1", m1.fail_count); end
    tick();
    checks++; if (m1.fail_pulse !== 1'b0) begin failures++; $display("FAIL fail_pulse_ts13 got=%b exp=0", m1.fail_pulse); end
    go_to(19);
    x = 1'b1;
    tick();
    x = 1'b0;
    tick();
    checks++; if (m1.fail_pulse !== 1'b1) begin failures++; $display("FAIL fail_pulse_ts21 got=%b exp=1", m1.fail_pulse); end
    checks++; if (m1.fail_count !== 16'd2) begin failures++; $display("FAIL fail_count_2 got=%0d exp=2", m1.fail_count); end
    checks++; if (m1.first_fail_ts !== 32'd11) begin failures++; $display("FAIL first_fail_ts_held got=%0d exp=11", m1.first_fail_ts); end
  endtask

  task automatic test_overlap();
    logic exp_pass, exp_fail;
    do_reset();
    en = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      x = (c <= 3);
      y = (c >= 3 && c <= 5);
      exp_pass = (c >= 4 && c <= 6);
      exp_fail = (c == 7);
      checks++; if (m3.pass_pulse !== exp_pass) begin failures++; $display("FAIL overlap_pass_ts%0d got=%b exp=%b", c, m3.pass_pulse, exp_pass); end
      checks++; if (m3.fail_pulse !== exp_fail) begin failures++; $display("FAIL overlap_fail_ts%0d got=%b exp=%b", c, m3.fail_pulse, exp_fail); end
      tick();
    end
    checks++; if (m3.pass_count !== 16'd3) begin failures++; $display("FAIL overlap_pass_count got=%0d exp=3", m3.pass_count); end
    checks++; if (m3.fail_count !== 16'd1) begin failures++; $display("FAIL overlap_fail_count got=%0d exp=1", m3.fail_count); end
    checks++; if (m3.first_fail_ts !== 32'd6) begin failures++; $display("FAIL overlap_first_fail_ts got=%0d exp=6", m3.first_fail_ts); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    logic exp_fail;
    do_reset();
    en = 1'b1;
    y = 1'b0;
    for (int c = 0; c <= 23; c++) begin
      x = (c < 20);
      exp_cnt = (c < 2) ? 0 : ((c - 1 > 15) ? 15 : c - 1);
      exp_fail = (c >= 2 && c <= 21);
      checks++; if (m4.fail_count !== exp_cnt[3:0]) begin failures++; $display("FAIL sat_count_ts%0d got=%0d exp=%0d", c, m4.fail_count, exp_cnt); end
      checks++; if (m4.fail_pulse !== exp_fail) begin failures++; $display("FAIL sat_pulse_ts%0d got=%b exp=%b", c, m4.fail_pulse, exp_fail); end
      tick();
    end
  endtask

  task automatic test_reset_discard();
    do_reset();
    en = 1'b1;
    y = 1'b0;
    go_to(3);
    x = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    x = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (m2.fail_pulse !== 1'b0) begin failures++; $display("FAIL rst_discard_fail_pulse_%0d got=%b exp=0", k, m2.fail_pulse); end
      checks++; if (m2.pass_pulse !== 1'b0) begin failures++; $display("FAIL rst_discard_pass_pulse_%0d got=%b exp=0", k, m2.pass_pulse); end
      checks++; if (m2.pending !== 1'b0) begin failures++; $display("FAIL rst_discard_pending_%0d got=%b exp=0", k, m2.pending); end
      tick();
    end
    checks++; if (m2.fail_count !== 16'd0) begin failures++; $display("FAIL rst_discard_fail_count got=%0d exp=0", m2.fail_count); end
    checks++; if (m2.fail_sticky !== 1'b0) begin failures++; $display("FAIL rst_discard_sticky got=%b exp=0", m2.fail_sticky); end
  endtask

  task automatic test_clr_discard();
    do_reset();
    en = 1'b1;
    y = 1'b0;
    // First failure at ts=2, then obligations at ts=2,3 and x in the clr cycle (ts=4).
    for (int c = 0; c <= 4; c++) begin
      x = (c == 0) || (c >= 2);
      clr = (c == 4);
      if (c == 3) begin
        checks++; if (m2.fail_sticky !== 1'b1) begin failures++; $display("FAIL clr_pre_sticky got=%b exp=1", m2.fail_sticky); end
        checks++; if (m2.first_fail_ts !== 32'd2) begin failures++; $display("FAIL clr_pre_first_fail_ts got=%0d exp=2", m2.first_fail_ts); end
      end
      tick();
    end
    x = 1'b0; clr = 1'b0;
    checks++; if (m2.fail_sticky !== 1'b0) begin failures++; $display("FAIL clr_sticky got=%b exp=0", m2.fail_sticky); end
    checks++; if (m2.fail_count !== 16'd0) begin failures++; $display("FAIL clr_fail_count got=%0d exp=0", m2.fail_count); end
    checks++; if (m2.first_fail_ts !== 32'd0) begin failures++; $display("FAIL clr_first_fail_ts got=%0d exp=0", m2.first_fail_ts); end
    for (int k = 5; k <= 7; k++) begin
      checks++; if (m2.fail_pulse !== 1'b0) begin failures++; $display("FAIL clr_fail_pulse_ts%0d got=%b exp=0", k, m2.fail_pulse); end
      checks++; if (m2.pending !== 1'b0) begin failures++; $display("FAIL clr_pending_ts%0d got=%b exp=0", k, m2.pending); end
      tick();
    end
    x = 1'b1;
    tick();
    x = 1'b0;
    go_to(11);
    checks++; if (m2.fail_pulse !== 1'b1) begin failures++; $display("FAIL clr_after_fail_pulse got=%b exp=1", m2.fail_pulse); end
    checks++; if (m2.first_fail_ts !== 32'd10) begin failures++; $display("FAIL clr_ts_continues got=%0d exp=10", m2.first_fail_ts); end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    y = 1'b0;
    go_to(2);
    x = 1'b1;
    tick();
    x = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      checks++; if (m2.pending !== 1'b0) begin failures++; $display("FAIL en0_pending_ts%0d got=%b exp=0", c, m2.pending); end
      checks++; if (m2.fail_pulse !== 1'b0) begin failures++; $display("FAIL en0_fail_pulse_ts%0d got=%b exp=0", c, m2.fail_pulse); end
      tick();
    end
    do_reset();
    en = 1'b1;
    go_to(2);
    x = 1'b1;
    tick();
    x = 1'b0;
    en = 1'b0;
    checks++; if (m2.pending !== 1'b1) begin failures++; $display("FAIL en1_pending_ts3 got=%b exp=1", m2.pending); end
    tick();
    checks++; if (m2.pending !== 1'b1) begin failures++; $display("FAIL en1_pending_ts4 got=%b exp=1", m2.pending); end
    checks++; if (m2.fail_pulse !== 1'b0) begin failures++; $display("FAIL en1_fail_pulse_ts4 got=%b exp=0", m2.fail_pulse); end
    tick();
    checks++; if (m2.fail_pulse !== 1'b1) begin failures++; $display("FAIL en1_fail_pulse_ts5 got=%b exp=1", m2.fail_pulse); end
    checks++; if (m2.first_fail_ts !== 32'd4) begin failures++; $display("FAIL en1_first_fail_ts got=%0d exp=4", m2.first_fail_ts); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] y_pat;
    logic exp_pass, exp_fail;
    y_pat = 8'b0110_1010;
    do_reset();
    en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      x = (c <= 7);
      y = (c >= 1 && c <= 8) ? y_pat[c-1] : 1'b0;
      exp_pass = (c >= 2 && c <= 9) ? y_pat[c-2] : 1'b0;
      exp_fail = (c >= 2 && c <= 9) ? ~y_pat[c-2] : 1'b0;
      checks++; if (m1.pass_pulse !== exp_pass) begin failures++; $display("FAIL b2b_pass_ts%0d got=%b exp=%b", c, m1.pass_pulse, exp_pass); end
      checks++; if (m1.fail_pulse !== exp_fail) begin failures++; $display("FAIL b2b_fail_ts%0d got=%b exp=%b", c, m1.fail_pulse, exp_fail); end
      tick();
    end
    checks++; if (m1.pass_count !== 16'd4) begin failures++; $display("FAIL b2b_pass_count got=%0d exp=4", m1.pass_count); end
    checks++; if (m1.fail_count !== 16'd4) begin failures++; $display("FAIL b2b_fail_count got=%0d exp=4", m1.fail_count); end
    checks++; if (m1.first_fail_ts !== 32'd1) begin failures++; $display("FAIL b2b_first_fail_ts got=%0d exp=1", m1.first_fail_ts); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_first_ts();
    test_overlap();
    test_saturation();
    test_reset_discard();
    test_clr_discard();
    test_enable();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
